// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu : instruction fetch unit
//
// Issues one instruction-memory read at a time. The fetched word is held
// toward decode as an inst/PC/PC_S bundle until decode accepts it. The PC
// then advances by 4. A taken jump/branch from execute redirects the fetch
// stream. A response that belongs to a superseded request is dropped. A bus
// error halts the unit until reset.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a target that is not word aligned sets the
//               sticky misalign flag and halts the unit.
//   undefined : the low two bits of the redirect target are cleared, and
//               misalign stays 0.
//
// Parameters
//   DATA_LEN  width of the PC and of the memory address
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   imem_req_valid/_ready        fetch request handshake
//   imem_addr                    fetch address (the pc register)
//   imem_resp_valid/_rdata/_err  single-cycle read response
//   inst_valid/_ready            bundle handshake toward decode
//   inst, PC, PC_S               instruction, its address, and address + 4
//   redirect, redirect_pc        taken jump/branch target from execute
//   fetch_err                    sticky bus-error flag
//   misalign                     sticky misaligned-target flag
// -----------------------------------------------------------------------------
module ifu #(
  parameter int unsigned          DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_resp_err,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] PC,
  output logic [DATA_LEN-1:0] PC_S,
  input  logic                redirect,
  input  logic [DATA_LEN-1:0] redirect_pc,
  output logic                fetch_err,
  output logic                misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [DATA_LEN-1:0] PC_STEP = {{(DATA_LEN-3){1'b0}}, 3'b100};

  state_t              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic                kill_q, kill_d;
  logic [31:0]         inst_q, inst_d;
  logic [DATA_LEN-1:0] pc_out_q, pc_out_d;
  logic [DATA_LEN-1:0] pc_s_q, pc_s_d;
  logic                inst_valid_q, inst_valid_d;
  logic                fetch_err_q, fetch_err_d;
  logic                misalign_q, misalign_d;
  logic                req_valid_q, req_valid_d;

  logic [DATA_LEN-1:0] redirect_tgt_s;
  logic                redirect_bad_s;
  logic [DATA_LEN-1:0] pc_plus4_s;

`ifdef IFU_MISALIGN_CHECK_EN
  // The target is loaded unmodified. A misaligned target halts the unit.
  assign redirect_tgt_s = redirect_pc;
  assign redirect_bad_s = redirect & (redirect_pc[1:0] != 2'b00);
`else
  // The low target bits are dropped so that the fetch address stays aligned.
  logic unused_low_s;
  assign redirect_tgt_s = {redirect_pc[DATA_LEN-1:2], 2'b00};
  assign redirect_bad_s = 1'b0;
  assign unused_low_s   = ^redirect_pc[1:0];
`endif

  // Wraps modulo 2^DATA_LEN. No overflow flag is raised.
  assign pc_plus4_s = pc_q + PC_STEP;

  // Next-state and datapath logic for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    pc_s_d       = pc_s_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = fetch_err_q;
    misalign_d   = misalign_q;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // The old address is already on the bus. Its response must be dropped.
          if (redirect) begin
            kill_d = 1'b1;
            pc_d   = redirect_tgt_s;
          end else begin
            kill_d = 1'b0;
          end
        end else begin
          if (redirect) begin
            pc_d = redirect_tgt_s;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          // A redirect that arrives with the response also makes that response stale.
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect) begin
              pc_d = redirect_tgt_s;
            end else begin
              pc_d = pc_q;
            end
          end else if (imem_resp_err) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            inst_d       = imem_rdata;
            pc_out_d     = pc_q;
            pc_s_d       = pc_plus4_s;
            inst_valid_d = 1'b1;
            state_d      = S_OUT;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = redirect_tgt_s;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (redirect) begin
          inst_valid_d = 1'b0;
          pc_d         = redirect_tgt_s;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_plus4_s;
          state_d      = S_REQ;
        end else begin
          state_d = S_OUT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d      = S_HALT;
        inst_valid_d = 1'b0;
      end
    endcase

    // A misaligned target overrides every other transition and drops any pending response.
    if (redirect_bad_s && (state_q != S_HALT)) begin
      misalign_d   = 1'b1;
      pc_d         = redirect_pc;
      state_d      = S_HALT;
      kill_d       = 1'b1;
      inst_valid_d = 1'b0;
    end else begin
      misalign_d = misalign_q;
    end
  end

  // The request valid is registered from the next state, so it matches state==REQ.
  always_comb begin
    req_valid_d = 1'b0;
    if (state_d == S_REQ) begin
      req_valid_d = 1'b1;
    end else begin
      req_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= 32'h0000_0000;
      pc_out_q     <= {DATA_LEN{1'b0}};
      pc_s_q       <= {DATA_LEN{1'b0}};
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      misalign_q   <= 1'b0;
      req_valid_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      pc_s_q       <= pc_s_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      misalign_q   <= misalign_d;
      req_valid_q  <= req_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign PC             = pc_out_q;
  assign PC_S           = pc_s_q;
  assign fetch_err      = fetch_err_q;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu : self-checking bench for ifu
//
// The bench drives directed sequences and includes a memory model with a
// programmable response delay and error injection. A transaction-level
// reference model tracks three things: the expected fetch address, the
// outstanding request, and the expected bundle. Directed literal checks
// anchor the model. A second instance with RESET_PC=0xFFFFFFFC covers
// PC wrap-around.
// -----------------------------------------------------------------------------
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, PC, PC_S;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err, misalign;

  int total = 0;
  int bad   = 0;

  // memory model controls
  logic        mem_ready_en;
  int          mem_delay;
  logic        mem_err;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  ifu #(.DATA_LEN(32), .RESET_PC(32'h8000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_rdata(imem_rdata), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .PC(PC), .PC_S(PC_S),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .misalign(misalign)
  );

  // wrap-around instance
  logic        w_req_valid, w_resp_valid, w_inst_valid, w_fetch_err, w_misalign;
  logic        w_hs;
  logic [31:0] w_addr, w_inst, w_pc, w_pcs;
  logic        w_got, w_got2;
  logic [31:0] w_first_pc, w_first_pcs, w_next_addr;

  ifu #(.DATA_LEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_addr(w_addr), .imem_resp_valid(w_resp_valid),
    .imem_rdata(32'h0000_0013), .imem_resp_err(1'b0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1),
    .inst(w_inst), .PC(w_pc), .PC_S(w_pcs),
    .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .fetch_err(w_fetch_err), .misalign(w_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0073;
    return a ^ 32'h5a5a_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: accepts one request at a time and answers after mem_delay cycles.
  initial begin
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'h0; imem_resp_err = 1'b0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    forever begin
      @(negedge clk); #1;
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_rdata      = mem_word(pend_addr);
          imem_resp_err   = mem_err;
          pend            = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      imem_req_ready = mem_ready_en && !pend;
      if (!rst && imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_cnt  = mem_delay;
        pend_addr = imem_addr;
      end
    end
  end

  // Zero-wait responder for the wrap instance, plus capture of its first bundle.
  initial begin
    w_resp_valid = 1'b0; w_hs = 1'b0;
    w_got = 1'b0; w_got2 = 1'b0;
    w_first_pc = 32'hDEAD_BEEF; w_first_pcs = 32'hDEAD_BEEF; w_next_addr = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk); #1;
      w_resp_valid = w_hs;
      w_hs = w_req_valid && !rst;
      if (!rst && w_got && !w_got2 && w_req_valid) begin
        w_next_addr = w_addr;
        w_got2 = 1'b1;
      end
      if (!rst && w_inst_valid && !w_got) begin
        w_first_pc  = w_pc;
        w_first_pcs = w_pcs;
        w_got = 1'b1;
      end
    end
  end

  // Reference model: next fetch address, outstanding request, and held bundle.
  logic [31:0] m_fetch, m_iss, m_pc, m_inst, m_tgt;
  logic        m_valid, m_out, m_live, m_halt, m_err, m_mis, m_bad, m_req;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_fetch = 32'h8000_0000; m_valid = 1'b0; m_out = 1'b0; m_live = 1'b0;
        m_halt = 1'b0; m_err = 1'b0; m_mis = 1'b0;
      end else begin
`ifdef IFU_MISALIGN_CHECK_EN
        m_tgt = redirect_pc;
        m_bad = redirect && (redirect_pc[1:0] != 2'b00);
`else
        m_tgt = redirect_pc & 32'hFFFF_FFFC;
        m_bad = 1'b0;
`endif
        if (!m_halt) begin
          if (m_bad) begin
            m_halt = 1'b1; m_mis = 1'b1; m_valid = 1'b0; m_out = 1'b0;
          end else if (m_valid) begin
            if (redirect) begin
              m_valid = 1'b0; m_fetch = m_tgt;
            end else if (inst_ready) begin
              m_valid = 1'b0; m_fetch = m_pc + 32'd4;
            end
          end else if (m_out) begin
            if (imem_resp_valid) begin
              m_out = 1'b0;
              if (m_live && !redirect) begin
                if (imem_resp_err) begin
                  m_halt = 1'b1; m_err = 1'b1;
                end else begin
                  m_valid = 1'b1; m_pc = m_iss; m_inst = mem_word(m_iss);
                end
              end
            end else if (redirect) begin
              m_live = 1'b0;
            end
            if (redirect) m_fetch = m_tgt;
          end else begin
            if (imem_req_ready) begin
              m_out = 1'b1; m_iss = m_fetch; m_live = !redirect;
            end
            if (redirect) m_fetch = m_tgt;
          end
        end
      end
      m_req = !m_halt && !m_out && !m_valid;
      check("m_req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
      if (m_req) check("m_imem_addr", imem_addr, m_fetch);
      check("m_inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      if (m_valid) begin
        check("m_inst", inst, m_inst);
        check("m_pc", PC, m_pc);
        check("m_pc_s", PC_S, m_pc + 32'd4);
      end
      check("m_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      check("m_misalign", {31'b0, misalign}, {31'b0, m_mis});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_inst(input int maxc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (inst_valid) ok = 1'b1;
    end
    check("wait_inst", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_req(input int maxc, output logic saw_inst);
    logic ok;
    ok = 1'b0; saw_inst = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (inst_valid) saw_inst = 1'b1;
      if (imem_req_valid) ok = 1'b1;
    end
    check("wait_req", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  logic saw;

  initial begin
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ready_en = 1'b1; mem_delay = 0; mem_err = 1'b0;
    repeat (3) tick();
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_pc_s", PC_S, 32'h0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);

    // 1: first fetch with zero-wait memory
    rst = 1'b0;
    check("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_addr", imem_addr, 32'h8000_0000);
    tick();
    check("t1_c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    check("t1_c2_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("t1_inst", inst, 32'h0010_0073);
    check("t1_pc", PC, 32'h8000_0000);
    check("t1_pc_s", PC_S, 32'h8000_0004);

    // 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", {31'b0, inst_valid}, 32'd1);
      check("t2_hold_inst", inst, 32'h0010_0073);
      check("t2_hold_pc", PC, 32'h8000_0000);
      check("t2_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t2_next_req", {31'b0, imem_req_valid}, 32'd1);
    check("t2_next_addr", imem_addr, 32'h8000_0004);
    wait_inst(10);
    check("t2_pc", PC, 32'h8000_0004);
    check("t2_inst", inst, 32'hda5a_0017);

    // 3: redirect while waiting on a slow response
    mem_delay = 3;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    check("t3_in_wait", {31'b0, imem_req_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect = 1'b0;
    mem_delay = 0;
    wait_req(20, saw);
    check("t3_stale_dropped", {31'b0, saw}, 32'd0);
    check("t3_addr", imem_addr, 32'h8000_0100);
    wait_inst(10);
    check("t3_pc", PC, 32'h8000_0100);

    // 4: redirect and accept in the same cycle; redirect wins
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    inst_ready = 1'b0; redirect = 1'b0;
    check("t4_req", {31'b0, imem_req_valid}, 32'd1);
    check("t4_addr", imem_addr, 32'h8000_0200);
    wait_inst(10);
    check("t4_pc", PC, 32'h8000_0200);
    check("t4_pc_s", PC_S, 32'h8000_0204);

    // 6: misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    check("t6_misalign", {31'b0, misalign}, 32'd1);
    check("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("t6_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    check("t6_halt_no_req", {31'b0, imem_req_valid}, 32'd0);
`else
    check("t6_misalign", {31'b0, misalign}, 32'd0);
    check("t6_req", {31'b0, imem_req_valid}, 32'd1);
    check("t6_addr", imem_addr, 32'h8000_0100);
`endif

    // 5: bus error halts until reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wait_inst(10);
    check("t5_pc", PC, 32'h8000_0000);
    inst_ready = 1'b1; mem_err = 1'b1;
    tick();
    inst_ready = 1'b0;
    begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        tick();
        if (fetch_err) ok = 1'b1;
      end
      check("t5_fetch_err", {31'b0, ok}, 32'd1);
    end
    mem_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_halt_req", {31'b0, imem_req_valid}, 32'd0);
      check("t5_halt_valid", {31'b0, inst_valid}, 32'd0);
    end

    // 5b: reset in the middle of a wait; the late response must be ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5b_err_cleared", {31'b0, fetch_err}, 32'd0);
    wait_inst(10);
    mem_delay = 4;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_delay = 0;
    check("t5b_req", {31'b0, imem_req_valid}, 32'd1);
    check("t5b_addr", imem_addr, 32'h8000_0000);
    wait_inst(20);
    check("t5b_pc", PC, 32'h8000_0000);
    check("t5b_inst", inst, 32'h0010_0073);

    // wrap instance: PC_S of 0xFFFFFFFC wraps to 0
    check("wrap_seen", {30'b0, w_got, w_got2}, 32'd3);
    check("wrap_pc", w_first_pc, 32'hFFFF_FFFC);
    check("wrap_pc_s", w_first_pcs, 32'h0000_0000);
    check("wrap_next_addr", w_next_addr, 32'h0000_0000);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
